// File: rtl/num_guess_pkg.sv
// Shared types and constants for the num_guess binary-search initiator.
package num_guess_pkg;

  localparam int TRIES_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUESS = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FB_LT = 2'd0,
    FB_GT = 2'd1,
    FB_EQ = 2'd2
  } fb_e;

  // Equal outranks greater; neither flag set means the operand is below the guess.
  function automatic fb_e fb_decode(input logic gt, input logic eq);
    if (eq)      return FB_EQ;
    else if (gt) return FB_GT;
    return FB_LT;
  endfunction

endpackage

// File: rtl/num_guess_timer.sv
// Wait counter for missing feedback; expired fires on the waiting cycle that
// would bring the count to TIMEOUT, so the caller leaves on that same edge.
module num_guess_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_in;
      assign unused_in = clr ^ en ^ clk ^ rst;
      assign expired   = 1'b0;
    end else begin : g_on
      localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

      logic [CW-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clr)                     cnt_d = '0;
        else if (en && cnt_q != LAST) cnt_d = cnt_q + CW'(1);
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
      end

      assign expired = en && !clr && (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/num_guess.sv
// Binary-search initiator: offers guesses to a magnitude comparator and
// narrows [lo,hi] on gt/eq/lt feedback until a match, a contradiction or a timeout.
module num_guess
  import num_guess_pkg::*;
#(
  parameter int W       = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               fb_valid,
  input  logic               fb_gt,
  input  logic               fb_eq,
  output logic [W-1:0]       guess,
  output logic               guess_valid,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic               err,
  output logic [W-1:0]       result,
  output logic [TRIES_W-1:0] tries
);

  state_e             state_q, state_d;
  logic [W-1:0]       lo_q, lo_d, hi_q, hi_d;
  logic [W-1:0]       guess_q, guess_d, result_q, result_d;
  logic               found_q, found_d, err_q, err_d;
  logic [TRIES_W-1:0] tries_q, tries_d;
  logic               in_guess, accept, tmr_expired;
  fb_e                fb;

  // Sum in W+1 bits so lo+hi never wraps.
  function automatic logic [W-1:0] midpoint(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[W:1];
  endfunction

  assign in_guess = (state_q == GUESS);
  assign accept   = in_guess && fb_valid;
  assign fb       = fb_decode(fb_gt, fb_eq);

  num_guess_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (!in_guess || fb_valid),
    .en      (in_guess && !fb_valid),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    guess_d  = guess_q;
    result_d = result_q;
    found_d  = found_q;
    err_d    = err_q;
    tries_d  = tries_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          lo_d     = '0;
          hi_d     = '1;
          guess_d  = midpoint('0, '1);
          result_d = '0;
          found_d  = 1'b0;
          err_d    = 1'b0;
          tries_d  = '0;
          state_d  = GUESS;
        end
      end
      GUESS: begin
        if (accept) begin
          if (tries_q != '1) tries_d = tries_q + TRIES_W'(1);
          unique case (fb)
            FB_EQ: begin
              result_d = guess_q;
              found_d  = 1'b1;
              state_d  = DONE;
            end
            FB_GT: begin
              if (guess_q == hi_q) begin
                err_d   = 1'b1;
                state_d = DONE;
              end else begin
                lo_d    = guess_q + W'(1);
                guess_d = midpoint(lo_d, hi_q);
              end
            end
            default: begin
              if (guess_q == lo_q) begin
                err_d   = 1'b1;
                state_d = DONE;
              end else begin
                hi_d    = guess_q - W'(1);
                guess_d = midpoint(lo_q, hi_d);
              end
            end
          endcase
        end else if (tmr_expired) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= '1;
      guess_q  <= '0;
      result_q <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
      tries_q  <= '0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      guess_q  <= guess_d;
      result_q <= result_d;
      found_q  <= found_d;
      err_q    <= err_d;
      tries_q  <= tries_d;
    end
  end

  assign guess       = guess_q;
  assign guess_valid = in_guess;
  assign busy        = in_guess;
  assign done        = (state_q == DONE);
  assign found       = found_q;
  assign err         = err_q;
  assign result      = result_q;
  assign tries       = tries_q;

endmodule

// File: tb/tb_num_guess.sv
// Scoreboard bench for num_guess: directed searches push expected guesses and
// end-of-search records; a negedge monitor pops and compares.
module tb_num_guess;

  logic       clk = 1'b0;
  logic       rst, start, fb_valid, fb_gt, fb_eq;
  logic [3:0] guess, result;
  logic       guess_valid, busy, done, found, err;
  logic [7:0] tries;

  logic [3:0] hidden;
  int         mode;      // 0 exact comparator, 1 always gt, 2 always lt
  logic       force_eq;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_g[$];
  logic [13:0] exp_d[$];  // {found, err, result, tries}
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  assign fb_gt = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : (hidden > guess);
  assign fb_eq = (mode == 0) && ((hidden == guess) || force_eq);

  num_guess #(.W(4), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .fb_valid    (fb_valid),
    .fb_gt       (fb_gt),
    .fb_eq       (fb_eq),
    .guess       (guess),
    .guess_valid (guess_valid),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .err         (err),
    .result      (result),
    .tries       (tries)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every accepted guess and every done cycle is checked against the queues.
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (guess_valid && fb_valid) begin
        if (exp_g.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL guess_unexpected: got %0d expected none", guess);
        end else chk("guess", guess, exp_g.pop_front());
      end
      if (done) begin
        chk("done_pulse", prev_done, 0);
        if (exp_d.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL done_unexpected: got 0x%0h expected none", {found, err, result, tries});
        end else chk("done_rec", {found, err, result, tries}, exp_d.pop_front());
      end
      prev_done = done;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_done: got no done expected done within %0d cycles", budget);
    end
    @(posedge clk); #1;
  endtask

  task automatic push5(input int n, input int a, input int b, input int c, input int d, input int e);
    int v[5];
    v = '{a, b, c, d, e};
    for (int i = 0; i < n; i++) exp_g.push_back(v[i]);
  endtask

  initial begin
    logic early;
    rst = 1'b1; start = 1'b0; fb_valid = 1'b0; force_eq = 1'b0; mode = 0; hidden = '0;
    #2;
    chk("reset_outs", {busy, guess_valid, done, found, err, guess, result, tries}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Exact responder, hidden 11
    hidden = 4'd11; mode = 0; fb_valid = 1'b1;
    push5(2, 7, 11, 0, 0, 0); exp_d.push_back({1'b1, 1'b0, 4'd11, 8'd2});
    pulse_start();
    chk("first_guess", guess, 7);
    wait_done(20);
    chk("hold_after_done", {busy, found, err, result, tries}, {1'b0, 1'b1, 1'b0, 4'd11, 8'd2});

    // Boundaries 0 and 15
    hidden = 4'd0;
    push5(4, 7, 3, 1, 0, 0); exp_d.push_back({1'b1, 1'b0, 4'd0, 8'd4});
    pulse_start(); wait_done(20);
    hidden = 4'd15;
    push5(5, 7, 11, 13, 14, 15); exp_d.push_back({1'b1, 1'b0, 4'd15, 8'd5});
    pulse_start(); wait_done(20);

    // Inconsistent feedback
    mode = 1;
    push5(5, 7, 11, 13, 14, 15); exp_d.push_back({1'b0, 1'b1, 4'd0, 8'd5});
    pulse_start(); wait_done(20);
    mode = 2;
    push5(4, 7, 3, 1, 0, 0); exp_d.push_back({1'b0, 1'b1, 4'd0, 8'd4});
    pulse_start(); wait_done(20);
    mode = 0;

    // Timeout: 16 waiting cycles
    fb_valid = 1'b0;
    exp_d.push_back({1'b0, 1'b1, 4'd0, 8'd0});
    pulse_start();
    early = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) early = 1'b1;
    end
    chk("timeout_early", early, 0);
    @(posedge clk); #1;
    chk("timeout_at_16", {done, err, busy}, 3'b110);
    wait_done(4);

    // Response on the 15th waiting cycle still counts
    hidden = 4'd11;
    push5(2, 7, 11, 0, 0, 0); exp_d.push_back({1'b1, 1'b0, 4'd11, 8'd2});
    pulse_start();
    repeat (14) begin @(posedge clk); #1; end
    chk("late_no_err", {busy, err}, 2'b10);
    fb_valid = 1'b1;
    wait_done(10);
    fb_valid = 1'b0;

    // Bursty feedback, start while busy, gt+eq together on the 2nd response
    hidden = 4'd13;
    push5(2, 7, 11, 0, 0, 0); exp_d.push_back({1'b1, 1'b0, 4'd11, 8'd2});
    pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; fb_valid = 1'b1;
    @(posedge clk); #1 fb_valid = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 fb_valid = 1'b1; force_eq = 1'b1;
    @(posedge clk); #1 fb_valid = 1'b0; force_eq = 1'b0;
    wait_done(10);

    // Asynchronous reset mid-search, then a clean restart
    hidden = 4'd0; fb_valid = 1'b1;
    push5(2, 7, 3, 0, 0, 0);
    pulse_start();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_guess", guess, 1);
    fb_valid = 1'b0;
    #1 rst = 1'b1;
    #1 chk("rst_mid", {busy, guess_valid, done, found, err, guess, result, tries}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    fb_valid = 1'b1;
    push5(4, 7, 3, 1, 0, 0); exp_d.push_back({1'b1, 1'b0, 4'd0, 8'd4});
    pulse_start();
    chk("restart", {guess, tries}, {4'd7, 8'd0});
    wait_done(20);
    fb_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("guess_queue_empty", exp_g.size(), 0);
    chk("done_queue_empty", exp_d.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
